memory_dump_reader: RTL and testbench

MEMORY_DUMP_READER -- requirements
Module: memory_dump_reader

---
 rtl/memory_dump_reader.sv | 113 +++++++++++
 tb/tb_memory_dump_reader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/memory_dump_reader.sv
// Streams a contiguous range of words out of an async-read memory through a
// valid/ready port. Optional running checksum: define MEMORY_DUMP_CHECKSUM_EN.
module memory_dump_reader #(
    parameter int BITSIZE  = 32,
    parameter int ADDRSIZE = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDRSIZE-1:0] start_addr,
    input  logic [ADDRSIZE:0]   word_count,
    input  logic                abort,
    output logic [ADDRSIZE-1:0] mem_addr,
    input  logic [BITSIZE-1:0]  mem_rdata,
    output logic [BITSIZE-1:0]  dout,
    output logic [ADDRSIZE-1:0] dout_addr,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                busy,
    output logic                done,
    output logic [BITSIZE-1:0]  checksum
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_HOLD, S_DONE} state_t;

    localparam logic [ADDRSIZE:0] REM_ONE = (ADDRSIZE+1)'(1);

    state_t                r_state;
    state_t                w_next;
    logic [ADDRSIZE-1:0]   r_addr;
    logic [ADDRSIZE:0]     r_rem;
    logic [BITSIZE-1:0]    r_dout;
    logic [ADDRSIZE-1:0]   r_dout_addr;
    logic                  r_dout_valid;
    logic                  w_start_ok;
    logic                  w_hs;

    // abort beats both a new start and a pending handshake
    assign w_start_ok = (r_state == S_IDLE) && start && !abort;
    assign w_hs       = (r_state == S_HOLD) && r_dout_valid && dout_ready && !abort;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start_ok) w_next = (word_count == '0) ? S_DONE : S_READ;
            S_READ: w_next = abort ? S_IDLE : S_HOLD;
            S_HOLD: begin
                if (abort)     w_next = S_IDLE;
                else if (w_hs) w_next = (r_rem == REM_ONE) ? S_DONE : S_READ;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_rem        <= '0;
            r_dout       <= '0;
            r_dout_addr  <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            if (w_start_ok && word_count != '0) begin
                r_addr <= start_addr;
                r_rem  <= word_count;
            end
            if (r_state == S_READ && !abort) begin
                r_dout       <= mem_rdata;
                r_dout_addr  <= r_addr;
                r_dout_valid <= 1'b1;
            end
            if (w_hs) begin
                r_dout_valid <= 1'b0;
                if (r_rem != REM_ONE) begin
                    r_addr <= r_addr + ADDRSIZE'(1);
                    r_rem  <= r_rem - REM_ONE;
                end
            end
            if (abort && r_state != S_IDLE) r_dout_valid <= 1'b0;
        end
    end

`ifdef MEMORY_DUMP_CHECKSUM_EN
    logic [BITSIZE-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (reset)           r_checksum <= '0;
        else if (w_start_ok) r_checksum <= '0;
        else if (w_hs)       r_checksum <= r_checksum + r_dout;
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign mem_addr   = r_addr;
    assign dout       = r_dout;
    assign dout_addr  = r_dout_addr;
    assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_memory_dump_reader.sv
// Directed bench for memory_dump_reader: table of dumps plus abort/reset sequences.
module tb_memory_dump_reader;

    logic        clk = 1'b0;
    logic        reset, start, abort, dout_ready;
    logic [15:0] start_addr, mem_addr, dout_addr;
    logic [16:0] word_count;
    logic [31:0] mem_rdata, dout, checksum;
    logic        dout_valid, busy, done;

    logic [31:0] mem [0:65535];
    int n_chk = 0;
    int n_fail = 0;

    assign mem_rdata = mem[mem_addr];

    memory_dump_reader #(.BITSIZE(32), .ADDRSIZE(16)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .word_count(word_count), .abort(abort), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .dout(dout), .dout_addr(dout_addr),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy),
        .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] saddr;
        logic [16:0] cnt;
        int          stall_idx;
        int          stall_len;
        bit          glitch;
        logic [15:0] last_addr;
        logic [31:0] sum;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_sum(input logic [31:0] s);
`ifdef MEMORY_DUMP_CHECKSUM_EN
        return s;
`else
        return (s & 32'h0);
`endif
    endfunction

    task automatic run_dump(input vec_t v);
        int idx, stalled, dones;
        bit hs_prev;
        logic [15:0] a, last;
        @(negedge clk);
        start_addr = v.saddr; word_count = v.cnt; start = 1'b1; dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; idx = 0; stalled = 0; dones = 0; hs_prev = 0; last = '0;
        for (int cyc = 1; cyc < 300; cyc++) begin
            if (hs_prev) check("valid_drop", dout_valid, 0);
            hs_prev = 0;
            // a start while busy must not disturb the running dump
            if (v.glitch && (cyc == 3 || cyc == 4)) begin
                start = 1'b1; start_addr = 16'h0500; word_count = 17'd7;
            end else start = 1'b0;
            if (dout_valid) begin
                a = v.saddr + 16'(idx);
                check("dout_addr", dout_addr, a);
                check("dout", dout, mem[a]);
                check("busy_hi", busy, 1);
                if (idx == v.stall_idx && stalled < v.stall_len) begin
                    dout_ready = 1'b0; stalled++;
                end else begin
                    dout_ready = 1'b1; idx++; hs_prev = 1; last = dout_addr;
                end
            end
            if (done) begin
                dones++;
                if (v.cnt != 0) begin
                    check("done_cycle", cyc, 2 * int'(v.cnt) + 1 + v.stall_len);
                    check("last_addr", last, v.last_addr);
                end else check("zero_done_lat", (cyc <= 2), 1);
                check("word_total", idx, v.cnt);
                check("checksum", checksum, exp_sum(v.sum));
                @(negedge clk);
                check("done_one_cycle", done, 0);
                check("idle_after", busy, 0);
                check("checksum_hold", checksum, exp_sum(v.sum));
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_count", dones, 1);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'(i) + 32'h100;
        mem[16'h0010] = 32'd1; mem[16'h0011] = 32'd2;
        mem[16'h0012] = 32'd3; mem[16'h0013] = 32'd4;

        vecs[0] = '{16'h0010, 17'd4, -1, 0, 1'b0, 16'h0013, 32'd10};
        vecs[1] = '{16'hFFFE, 17'd3, -1, 0, 1'b0, 16'h0000, 32'h000202FD};
        vecs[2] = '{16'h0010, 17'd4,  1, 5, 1'b0, 16'h0013, 32'd10};
        vecs[3] = '{16'h0020, 17'd0, -1, 0, 1'b0, 16'h0000, 32'd0};
        vecs[4] = '{16'h0010, 17'd4, -1, 0, 1'b1, 16'h0013, 32'd10};

        reset = 1'b1; start = 1'b0; abort = 1'b0; dout_ready = 1'b0;
        start_addr = '0; word_count = '0;
        repeat (2) @(negedge clk);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_dout", dout, 0);
        check("rst_dout_addr", dout_addr, 0);
        check("rst_checksum", checksum, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_dump(vecs[i]);

        // abort together with start in IDLE keeps the block idle
        @(negedge clk);
        start_addr = 16'h0010; word_count = 17'd4; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", busy, 0);
        check("abort_start_done", done, 0);

        // abort while holding the second word
        begin
            bit hit = 0;
            start = 1'b1; dout_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int c = 0; c < 50 && !hit; c++) begin
                if (dout_valid && dout_addr == 16'h0011) begin
                    dout_ready = 1'b0; abort = 1'b1; hit = 1;
                end
                @(negedge clk);
            end
            abort = 1'b0;
            check("abort_reached", hit, 1);
            check("abort_busy", busy, 0);
            check("abort_valid", dout_valid, 0);
            check("abort_done", done, 0);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check("abort_no_done", done, 0);
            end
        end
        run_dump(vecs[0]);

        // reset during READ clears every output
        start_addr = 16'h0020; word_count = 17'd4; start = 1'b1; dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pre_rst_busy", busy, 1);
        reset = 1'b1; abort = 1'b1;
        @(negedge clk);
        reset = 1'b0; abort = 1'b0;
        check("mid_rst_mem_addr", mem_addr, 0);
        check("mid_rst_dout", dout, 0);
        check("mid_rst_dout_addr", dout_addr, 0);
        check("mid_rst_checksum", checksum, 0);
        check("mid_rst_valid", dout_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("mid_rst_no_done", done, 0);
        end
        run_dump(vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
